// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings and flag bit positions for the pipelined ALU.
// Optional build macro used by this block: ALU_SAT_EN (signed saturation).
package alu_pipe_pkg;

    localparam logic [2:0] OP_NOT = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_DEC = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_INC = 3'b111;

    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;

endpackage

// File: rtl/alu_pipe_core.sv
// Combinational ALU datapath: op/A/B -> result and {V,C,N,Z} flags.
// With ALU_SAT_EN defined, signed overflow clamps the arithmetic result.
module alu_pipe_core
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH-1:0] operand;
    logic             subtract;
    logic             same_sign;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] raw;
    logic             carry;
    logic             overflow;

    // INC/DEC reuse the adder with a constant 1 as the second operand,
    // so carry/borrow and overflow fall out of the same WIDTH+1 bit sum.
    always_comb begin
        subtract  = (op == OP_DEC) || (op == OP_SUB);
        operand   = ((op == OP_ADD) || (op == OP_SUB)) ? b : WIDTH'(1);
        sum       = subtract ? ({1'b0, a} - {1'b0, operand})
                             : ({1'b0, a} + {1'b0, operand});
        same_sign = ~(a[MSB] ^ operand[MSB]);
        carry     = 1'b0;
        overflow  = 1'b0;
        case (op)
            OP_NOT:  raw = ~a;
            OP_AND:  raw = a & b;
            OP_XOR:  raw = a ^ b;
            OP_OR:   raw = a | b;
            default: begin
                raw      = sum[MSB:0];
                carry    = sum[WIDTH];
                overflow = (subtract ? ~same_sign : same_sign) & (raw[MSB] ^ a[MSB]);
            end
        endcase
    end

    // Overflow direction always follows the sign of A for both add and subtract.
    always_comb begin
`ifdef ALU_SAT_EN
        if (overflow)
            result = a[MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
        else
            result = raw;
`else
        result = raw;
`endif
        flags        = '0;
        flags[FLG_Z] = (result == '0);
        flags[FLG_N] = result[MSB];
        flags[FLG_C] = carry;
        flags[FLG_V] = overflow;
    end

endmodule

// File: rtl/alu_pipe.sv
// Two-stage registered ALU with valid/ready on both sides and full throughput.
// Optional build macro: ALU_SAT_EN (passed through to alu_pipe_core).
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [3:0]       out_flags
);

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s2_valid;
    logic             s1_advance;
    logic [WIDTH-1:0] core_result;
    logic [3:0]       core_flags;

    // in_ready looks through to out_ready so a full pipe still takes a beat
    // in the same cycle it emits one.
    assign s1_advance = !s2_valid || out_ready;
    assign in_ready   = !s1_valid || s1_advance;
    assign out_valid  = s2_valid;

    alu_pipe_core #(.WIDTH(WIDTH)) u_core (
        .op     (s1_op),
        .a      (s1_a),
        .b      (s1_b),
        .result (core_result),
        .flags  (core_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else begin
            if (in_ready)
                s1_valid <= in_valid;
            if (in_valid && in_ready) begin
                s1_a  <= in_a;
                s1_b  <= in_b;
                s1_op <= in_op;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid   <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else if (s1_advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= core_result;
                out_flags  <= core_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed corner cases at WIDTH=32, then
// randomized traffic on WIDTH=32 and WIDTH=8 instances against a reference model.
module tb_alu_pipe;

    typedef struct {
        logic [31:0] r;
        logic [3:0]  f;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_op;
    logic        out_ready;

    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_result;
    logic [3:0]  out_flags;

    logic        in_ready8;
    logic        out_valid8;
    logic [7:0]  out_result8;
    logic [3:0]  out_flags8;

    int checks = 0;
    int errors = 0;

    exp_t q32[$];
    exp_t q8[$];

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    alu_pipe #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready8),
        .in_a       (in_a[7:0]),
        .in_b       (in_b[7:0]),
        .in_op      (in_op),
        .out_valid  (out_valid8),
        .out_ready  (out_ready),
        .out_result (out_result8),
        .out_flags  (out_flags8)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Reference model: exact integer arithmetic on unsigned and signed views,
    // then wrap (or clamp) into w bits.
    function automatic exp_t model(input int w, input logic [2:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint mask = (longint'(1) << w) - 1;
        longint half = longint'(1) << (w - 1);
        longint ua = longint'(a) & mask;
        longint ub = longint'(b) & mask;
        longint sa = (ua >= half) ? ua - 2 * half : ua;
        longint sb = (ub >= half) ? ub - 2 * half : ub;
        longint rhs_u, rhs_s, u_exact, s_exact, r;
        logic   c = 1'b0;
        logic   v = 1'b0;
        case (op)
            3'd0: r = ~ua & mask;
            3'd1: r = ua & ub;
            3'd2: r = ua ^ ub;
            3'd3: r = ua | ub;
            default: begin
                rhs_u = (op == 3'd5 || op == 3'd6) ? ub : 1;
                rhs_s = (op == 3'd5 || op == 3'd6) ? sb : 1;
                if (op == 3'd4 || op == 3'd6) begin
                    u_exact = ua - rhs_u;
                    s_exact = sa - rhs_s;
                    c = (u_exact < 0);
                end else begin
                    u_exact = ua + rhs_u;
                    s_exact = sa + rhs_s;
                    c = (u_exact > mask);
                end
                v = (s_exact >= half) || (s_exact < -half);
                r = u_exact & mask;
`ifdef ALU_SAT_EN
                if (v) r = (s_exact > 0) ? half - 1 : half;
`endif
            end
        endcase
        e.r = 32'(r);
        e.f = {v, c, (r >= half), (r == 0)};
        return e;
    endfunction

    function automatic logic [31:0] randVal();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return {4{8'h7F}};
            5:       return {4{8'h80}};
            default: return $urandom;
        endcase
    endfunction

    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        @(negedge clk);
        in_op    = o;
        in_a     = x;
        in_b     = y;
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic expectResult(input string tag, input logic [31:0] r, input logic [3:0] f);
        int n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_valid"}, out_valid, 1);
        checkOutput(tag, {out_flags, out_result}, {f, r});
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [35:0] snap;
        logic        prev_stall32, prev_stall8;
        logic [35:0] prev_out32;
        logic [11:0] prev_out8;
        exp_t        e;
        int          accepted, k, got, n;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = '0;
        out_ready = 1'b1;
        #12;
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_out_result", out_result, 0);
        checkOutput("reset_out_flags", out_flags, 0);
        checkOutput("reset_in_ready", in_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // Back-to-back stream with no back-pressure.
        begin
            logic [2:0]  ops[4] = '{3'd5, 3'd6, 3'd1, 3'd7};
            logic [31:0] as[4]  = '{32'd5, 32'd3, 32'hF0, 32'hFFFF_FFFF};
            logic [31:0] bs[4]  = '{32'd3, 32'd5, 32'h3C, 32'd0};
            logic [31:0] rs[4]  = '{32'h8, 32'hFFFF_FFFE, 32'h30, 32'h0};
            logic [3:0]  fs[4]  = '{4'b0000, 4'b0110, 4'b0000, 4'b0101};
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (i < 4) begin
                    in_op = ops[i]; in_a = as[i]; in_b = bs[i]; in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
                #1;
                if (i < 4) checkOutput($sformatf("stream_in_ready%0d", i), in_ready, 1);
                if (i >= 2) begin
                    checkOutput($sformatf("stream_valid%0d", i - 2), out_valid, 1);
                    checkOutput($sformatf("stream_beat%0d", i - 2),
                                {out_flags, out_result}, {fs[i-2], rs[i-2]});
                end
            end
        end

        // Overflow and edge operations.
        applyStimulus(3'd5, 32'h7FFF_FFFF, 32'h1);
`ifdef ALU_SAT_EN
        expectResult("add_ovf", 32'h7FFF_FFFF, 4'b1000);
`else
        expectResult("add_ovf", 32'h8000_0000, 4'b1010);
`endif
        applyStimulus(3'd6, 32'h8000_0000, 32'h1);
`ifdef ALU_SAT_EN
        expectResult("sub_ovf", 32'h8000_0000, 4'b1010);
`else
        expectResult("sub_ovf", 32'h7FFF_FFFF, 4'b1000);
`endif
        applyStimulus(3'd4, 32'h0, 32'h1234);
        expectResult("dec_zero", 32'hFFFF_FFFF, 4'b0110);
        applyStimulus(3'd0, 32'h0, 32'h0);
        expectResult("not_zero", 32'hFFFF_FFFF, 4'b0010);
        applyStimulus(3'd2, 32'hA5A5_1234, 32'hA5A5_1234);
        expectResult("xor_self", 32'h0, 4'b0001);
        applyStimulus(3'd7, 32'h7FFF_FFFF, 32'h0);
`ifdef ALU_SAT_EN
        expectResult("inc_ovf", 32'h7FFF_FFFF, 4'b1000);
`else
        expectResult("inc_ovf", 32'h8000_0000, 4'b1010);
`endif

        // Back-pressure: four cycles of stall with a producer that always has data.
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        accepted  = 0;
        k         = 0;
        snap      = '0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c == 3) begin
                checkOutput("bp_hold_valid", out_valid, 1);
                checkOutput("bp_hold_data", {out_flags, out_result}, snap);
            end
            in_op = 3'd5; in_a = 32'd100 + 32'(k); in_b = 32'(k); in_valid = 1'b1;
            #1;
            if (c == 2) snap = {out_flags, out_result};
            if (in_ready) begin
                accepted++;
                k++;
            end
        end
        checkOutput("bp_accepted", accepted, 2);
        checkOutput("bp_in_ready", in_ready, 0);
        got = 0;
        n   = 0;
        while (got < 2 && n < 10) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid) begin
                checkOutput($sformatf("bp_release%0d", got), {out_flags, out_result},
                            {4'b0000, 32'd100 + 32'(2 * got)});
                got++;
            end
            n++;
        end
        checkOutput("bp_release_count", got, 2);
        @(negedge clk);
        #1;
        checkOutput("bp_no_duplicate", out_valid, 0);

        // Reset with both stages occupied.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_op = 3'd5; in_a = 32'd1; in_b = 32'd1; in_valid = 1'b1;
        end
        @(negedge clk);
        checkOutput("rst_pre_full", {out_valid, in_ready}, 2'b10);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_mid_out_valid", out_valid, 0);
        checkOutput("rst_mid_out_result", out_result, 0);
        checkOutput("rst_mid_out_flags", out_flags, 0);
        checkOutput("rst_mid_in_ready", in_ready, 1);
        in_valid = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("rst_no_stale", out_valid, 0);
        end
        checkOutput("rst_after_in_ready", in_ready, 1);

        // Random traffic on both widths.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        q32.delete();
        q8.delete();
        prev_stall32 = 1'b0;
        prev_stall8  = 1'b0;
        prev_out32   = '0;
        prev_out8    = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            if (prev_stall32) begin
                checkOutput("hold_valid32", out_valid, 1);
                checkOutput("hold_data32", {out_flags, out_result}, prev_out32);
            end
            if (prev_stall8) begin
                checkOutput("hold_valid8", out_valid8, 1);
                checkOutput("hold_data8", {out_flags8, out_result8}, prev_out8);
            end
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_op     = 3'($urandom);
            in_a      = randVal();
            in_b      = randVal();
            #1;
            if (out_valid && out_ready) begin
                if (q32.size() == 0) checkOutput("spurious32", 1, 0);
                else begin
                    e = q32.pop_front();
                    checkOutput("rand32", {out_flags, out_result}, {e.f, e.r});
                end
            end
            if (in_valid && in_ready) q32.push_back(model(32, in_op, in_a, in_b));
            if (out_valid8 && out_ready) begin
                if (q8.size() == 0) checkOutput("spurious8", 1, 0);
                else begin
                    e = q8.pop_front();
                    checkOutput("rand8", {out_flags8, out_result8}, {e.f, e.r[7:0]});
                end
            end
            if (in_valid && in_ready8) q8.push_back(model(8, in_op, in_a, in_b));
            prev_stall32 = out_valid && !out_ready;
            prev_stall8  = out_valid8 && !out_ready;
            prev_out32   = {out_flags, out_result};
            prev_out8    = {out_flags8, out_result8};
        end

        n = 0;
        while ((q32.size() != 0 || q8.size() != 0) && n < 20) begin
            @(negedge clk);
            in_valid  = 1'b0;
            out_ready = 1'b1;
            #1;
            if (out_valid && q32.size() != 0) begin
                e = q32.pop_front();
                checkOutput("drain32", {out_flags, out_result}, {e.f, e.r});
            end
            if (out_valid8 && q8.size() != 0) begin
                e = q8.pop_front();
                checkOutput("drain8", {out_flags8, out_result8}, {e.f, e.r[7:0]});
            end
            n++;
        end
        checkOutput("drain_left32", q32.size(), 0);
        checkOutput("drain_left8", q8.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
